alu_op_sequencer: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the register-file/ALU datapath (`main_design`) and drives its `opcode`, `we`, `a1`, `a2`, `a3` and `wd3` inputs. It consumes its `result`. The sequencer accepts one 32-bit instruction at a time over a valid/ready handshake and executes it: load-immediate, ALU op with write-back, or ALU op without write-back. It returns ALU results on a second valid/ready port. Each instruction completes its register write before the next instruction is accepted, so the datapath never sees a read-after-write hazard.

---
 rtl/alu_op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle instruction sequencer in front of the register-file/ALU
// datapath. It accepts one 32-bit instruction at a time, drives the datapath read/write
// ports, and returns ALU results over a valid/ready port. Every instruction finishes its
// register write before the next one is accepted, so the datapath never sees a hazard.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake, in_instr = instruction word
//   res_valid/res_ready      result handshake, res_data = ALU result
//   opcode, a1, a2           datapath ALU operation and read addresses
//   we, a3, wd3              datapath register-file write port
//   result                   datapath ALU output (combinational from a1/a2/opcode)
//   err                      sticky illegal-instruction flag
//   retired                  wrapping count of completed legal instructions
//
// Instruction word: [31:30] class, [29:28] aluop, [27:23] rd, [22:18] rs1,
// [17:13] rs2; LOADI uses [17:0] as a zero-extended immediate.
module alu_op_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [1:0]       opcode,
    output logic             we,
    output logic [4:0]       a1,
    output logic [4:0]       a2,
    output logic [4:0]       a3,
    output logic [31:0]      wd3,
    input  logic [31:0]      result,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned IMM_W = 18;

    localparam logic [1:0] CLS_LOADI   = 2'b00;
    localparam logic [1:0] CLS_ALU_WB  = 2'b01;
    localparam logic [1:0] CLS_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_OUT
    } state_e;

    state_e            state_q,     state_d;
    logic [XLEN-1:0]   instr_q,     instr_d;
    logic [XLEN-1:0]   res_q,       res_d;
    logic [CNT_W-1:0]  retired_q,   retired_d;
    logic              err_q,       err_d;

    logic              in_ready_q,  in_ready_d;
    logic              we_q,        we_d;
    logic              res_valid_q, res_valid_d;
    logic [XLEN-1:0]   res_data_q,  res_data_d;
    logic [OP_W-1:0]   opcode_q,    opcode_d;
    logic [REG_W-1:0]  a1_q,        a1_d;
    logic [REG_W-1:0]  a2_q,        a2_d;
    logic [REG_W-1:0]  a3_q,        a3_d;
    logic [XLEN-1:0]   wd3_q,       wd3_d;

    // Next-state logic, then output decode from the next state so outputs leave flops.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        res_d       = res_q;
        retired_d   = retired_q;
        err_d       = err_q;

        in_ready_d  = 1'b0;
        we_d        = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = '0;
        opcode_d    = '0;
        a1_d        = '0;
        a2_d        = '0;
        a3_d        = '0;
        wd3_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    if (in_instr[31:30] == CLS_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (in_instr[31:30] == CLS_LOADI) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                res_d   = result;
                state_d = (instr_q[31:30] == CLS_ALU_WB) ? S_WB : S_OUT;
            end
            S_WB: begin
                if (instr_q[31:30] == CLS_LOADI) begin
                    state_d   = S_IDLE;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d   = S_IDLE;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE: in_ready_d = 1'b1;
            S_EXEC: begin
                a1_d     = instr_d[22:18];
                a2_d     = instr_d[17:13];
                opcode_d = instr_d[29:28];
            end
            S_WB: begin
                we_d  = 1'b1;
                a3_d  = instr_d[27:23];
                wd3_d = (instr_d[31:30] == CLS_LOADI) ? XLEN'(instr_d[IMM_W-1:0]) : res_d;
            end
            S_OUT: begin
                res_valid_d = 1'b1;
                res_data_d  = res_d;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers; reset drops any in-flight write or result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            res_q       <= '0;
            retired_q   <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            opcode_q    <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            wd3_q       <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            res_q       <= res_d;
            retired_q   <= retired_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            opcode_q    <= opcode_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign we        = we_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign opcode    = opcode_q;
    assign a1        = a1_q;
    assign a2        = a2_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;
    assign err       = err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a register-file/ALU datapath stand-in, a transaction-level
// reference model (per-instruction list of expected output steps plus an architectural
// register file), a per-cycle compare process, and directed plus randomized stimulus.
module tb_alu_op_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             res_ready = 1'b1;
    logic [31:0]      in_instr  = '0;
    logic             in_ready;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [1:0]       opcode;
    logic             we;
    logic [4:0]       a1, a2, a3;
    logic [31:0]      wd3;
    logic [31:0]      result;
    logic             err;
    logic [CNT_W-1:0] retired;

    alu_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .opcode    (opcode),
        .we        (we),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .wd3       (wd3),
        .result    (result),
        .err       (err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Datapath stand-in: register file written on the clock, combinational ALU.
    logic [31:0] rf [32];
    always @(posedge clk) if (we) rf[a3] <= wd3;
    assign result = alu(opcode, rf[a1], rf[a2]);

    // Reference model: each accepted instruction expands into the output steps it must show.
    typedef struct packed {
        logic        we;
        logic [4:0]  a1, a2, a3;
        logic [1:0]  op;
        logic [31:0] wd3;
        logic        rv;
        logic [31:0] rdat;
        logic        is_wb;
        logic        is_out;
        logic        retire;
    } step_t;

    step_t       q[$];
    logic [31:0] arch [32];
    logic        err_m     = 1'b0;
    int          retired_m = 0;

    task automatic model_accept(input logic [31:0] w);
        step_t       s;
        logic [31:0] v;
        v = alu(w[29:28], arch[w[22:18]], arch[w[17:13]]);
        case (w[31:30])
            2'b00: begin
                s = '0; s.we = 1'b1; s.a3 = w[27:23]; s.wd3 = {14'd0, w[17:0]};
                s.is_wb = 1'b1; s.retire = 1'b1; q.push_back(s);
            end
            2'b01, 2'b10: begin
                s = '0; s.a1 = w[22:18]; s.a2 = w[17:13]; s.op = w[29:28]; q.push_back(s);
                if (w[31:30] == 2'b01) begin
                    s = '0; s.we = 1'b1; s.a3 = w[27:23]; s.wd3 = v; s.is_wb = 1'b1; q.push_back(s);
                end
                s = '0; s.rv = 1'b1; s.rdat = v; s.is_out = 1'b1; s.retire = 1'b1; q.push_back(s);
            end
            default: err_m <= 1'b1;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            err_m     <= 1'b0;
            retired_m <= 0;
        end else if (q.size() == 0) begin
            if (in_valid) model_accept(in_instr);
        end else if (q[0].is_out) begin
            if (res_ready) begin
                void'(q.pop_front());
                retired_m <= (retired_m + 1) % (1 << CNT_W);
            end
        end else begin
            if (q[0].is_wb) arch[q[0].a3] <= q[0].wd3;
            if (q[0].retire) retired_m <= (retired_m + 1) % (1 << CNT_W);
            void'(q.pop_front());
        end
    end

    int errors = 0;
    int checks = 0;

    logic        obs_we_seen = 1'b0;
    logic        obs_rv_seen = 1'b0;
    logic [31:0] obs_wd3     = '0;
    logic [31:0] obs_res     = '0;

    typedef struct packed {
        logic             rdy;
        logic             we;
        logic [4:0]       a1, a2, a3;
        logic [1:0]       op;
        logic [31:0]      wd3;
        logic             rv;
        logic [31:0]      rdat;
        logic             e;
        logic [CNT_W-1:0] ret;
    } obs_t;

    // Per-cycle compare of every DUT output against the model's current step.
    always @(negedge clk) begin : compare
        obs_t  act;
        obs_t  exp;
        step_t s;
        if (rst_n) begin
            act = {in_ready, we, a1, a2, a3, opcode, wd3, res_valid, res_data, err, retired};
            exp = '0;
            if (q.size() == 0) begin
                exp.rdy = 1'b1;
            end else begin
                s = q[0];
                exp.we = s.we; exp.a1 = s.a1; exp.a2 = s.a2; exp.a3 = s.a3; exp.op = s.op;
                exp.wd3 = s.wd3; exp.rv = s.rv; exp.rdat = s.rdat;
            end
            exp.e   = err_m;
            exp.ret = CNT_W'(retired_m);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h (rdy,we,a1,a2,a3,op,wd3,rv,rdata,err,retired)",
                         $time, act, exp);
            end
            if (we) begin obs_we_seen = 1'b1; obs_wd3 = wd3; end
            if (res_valid) begin obs_rv_seen = 1'b1; obs_res = res_data; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    logic rand_rr = 1'b0;

    task automatic tick_inputs();
        if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] cls, input logic [1:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {cls, op, rd, rs1, rs2, 13'd0};
    endfunction

    function automatic logic [31:0] mk_li(input logic [4:0] rd, input logic [17:0] imm);
        return {4'b0000, rd, 5'd0, imm};
    endfunction

    // Offer an instruction until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_instr = w;
        while (!in_ready && n < 200) begin
            tick_inputs();
            @(negedge clk); #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_instr    = $urandom();
        obs_we_seen = 1'b0;
        obs_rv_seen = 1'b0;
        obs_wd3     = '0;
        obs_res     = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            tick_inputs();
            @(negedge clk); #1;
            n++;
        end while ((q.size() != 0 || !in_ready) && n < 200);
        if (n >= 200) chk("done_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic [31:0] w);
        send(w);
        wait_done();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] v;
        int          n;

        for (int i = 0; i < 32; i++) begin
            v = $urandom();
            rf[i]   <= v;
            arch[i] <= v;
        end

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // Write-back add: 5 + 3 -> r3.
        run(mk_li(5'd1, 18'd5));
        run(mk_li(5'd2, 18'd3));
        run(mk(2'b01, 2'd0, 5'd3, 5'd1, 5'd2));
        chk("add_wd3", obs_wd3, 32'd8);
        chk("add_res", obs_res, 32'd8);
        chk("add_retired", 32'(retired), 32'd3);

        // Wrapping sub: 3 - 5.
        run(mk_li(5'd1, 18'd3));
        run(mk_li(5'd2, 18'd5));
        run(mk(2'b01, 2'd1, 5'd4, 5'd1, 5'd2));
        chk("sub_wd3", obs_wd3, 32'hFFFF_FFFE);
        chk("sub_res", obs_res, 32'hFFFF_FFFE);

        // Result-only shift left: 1 << 4.
        run(mk_li(5'd1, 18'd1));
        run(mk_li(5'd2, 18'd4));
        run(mk(2'b10, 2'd2, 5'd0, 5'd1, 5'd2));
        chk("shl_res", obs_res, 32'd16);
        chk("shl_no_we", 32'(obs_we_seen), 32'd0);

        // Backpressure: consumer stalls for 5 cycles, handshake in the 6th.
        run(mk_li(5'd1, 18'd100));
        run(mk_li(5'd2, 18'd23));
        res_ready = 1'b0;
        send(mk(2'b10, 2'd1, 5'd0, 5'd1, 5'd2));
        n = 0;
        while (!res_valid && n < 20) begin @(negedge clk); #1; n++; end
        chk("bp_valid_rise", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_data", res_data, 32'd77);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(res_valid), 32'd0);
        chk("bp_retired", 32'(retired), 32'd12);

        // Illegal word, then a LOADI with the largest immediate.
        send({2'b11, 30'h2AB_CDEF});
        @(negedge clk); #1;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_in_ready", 32'(in_ready), 32'd1);
        chk("ill_no_we", 32'(obs_we_seen), 32'd0);
        chk("ill_no_res", 32'(obs_rv_seen), 32'd0);
        chk("ill_retired", 32'(retired), 32'd12);
        run(mk_li(5'd7, 18'h3FFFF));
        chk("li_max_wd3", obs_wd3, 32'h0003_FFFF);

        // Reset while the write-back of r9 is being driven.
        run(mk_li(5'd31, 18'd0));
        run(mk_li(5'd9, 18'h55));
        send(mk_li(5'd9, 18'h123));
        chk("rst_wb_we_before", 32'(we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run(mk(2'b10, 2'd0, 5'd0, 5'd9, 5'd31));
        chk("rst_r9_unwritten", obs_res, 32'h55);
        chk("rst_retired_after", 32'(retired), 32'd1);

        // Randomized traffic with random backpressure and back-to-back offers.
        rand_rr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            n = $urandom_range(0, 9);
            if (n < 3)      w[31:30] = 2'b00;
            else if (n < 6) w[31:30] = 2'b01;
            else if (n < 9) w[31:30] = 2'b10;
            else            w[31:30] = 2'b11;
            send(w);
            if ($urandom_range(0, 1) == 0) wait_done();
            repeat ($urandom_range(0, 2)) begin
                tick_inputs();
                @(negedge clk); #1;
            end
        end
        rand_rr   = 1'b0;
        res_ready = 1'b1;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
